// File: rtl/key_port.sv
// key_port: memory-mapped keypad responder. Synchronises and debounces raw key
// lines, turns debounced edges into event bytes queued in a small FIFO, and
// exposes DATA/STATUS/CTRL/KEYS registers at BASE..BASE+3.
// Optional build macro KEY_PORT_RELEASE_EVT_EN: when defined, release edges are
// queued as events too; otherwise only presses are queued.
module key_port #(
    parameter int unsigned BASE    = 980,
    parameter int unsigned N_KEYS  = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DEB_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr,
    input  logic              we,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic [N_KEYS-1:0] keys,
    output logic              key_int
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(DEB_DIV);

    localparam logic [15:0] A_DATA   = 16'(BASE);
    localparam logic [15:0] A_STATUS = 16'(BASE + 1);
    localparam logic [15:0] A_CTRL   = 16'(BASE + 2);
    localparam logic [15:0] A_KEYS   = 16'(BASE + 3);

    logic [N_KEYS-1:0] sync1, sync2;
    logic [N_KEYS-1:0] hist0, hist1;
    logic [N_KEYS-1:0] deb, pending;
    logic [N_KEYS-1:0] all_hi, all_lo, chg, set_mask;
    logic [PW-1:0]     presc;
    logic              tick;

    logic              enc_valid;
    logic [2:0]        enc_idx;
    logic [N_KEYS-1:0] enc_clr;
    logic              ev_dir;
    logic [7:0]        ev;

    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic              overflow, ie;
    logic              empty, full;
    logic              ctrl_wr, pop_req, ovf_clr, flush;
    logic              do_pop, push_req, do_push, drop;
    logic [7:0]        rd_data;

    logic              unused_din;
    assign unused_din = ^din[6:3];

    // Two-flop synchroniser for the asynchronous key lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    // Debounce sample prescaler; tick fires on the wrap cycle
    assign tick = (presc == PW'(DEB_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Three-sample agreement: the incoming sample plus the two stored ones
    assign all_hi = sync2 & hist0 & hist1;
    assign all_lo = ~(sync2 | hist0 | hist1);
    assign chg    = tick ? ((all_hi & ~deb) | (all_lo & deb)) : '0;

`ifdef KEY_PORT_RELEASE_EVT_EN
    assign set_mask = chg;
`else
    assign set_mask = chg & ~deb;
`endif

    // Sample history and debounced state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0 <= '0;
            hist1 <= '0;
            deb   <= '0;
        end else begin
            if (tick) begin
                hist0 <= sync2;
                hist1 <= hist0;
            end
            deb <= deb ^ chg;
        end
    end

    // Lowest-index pending key selects this cycle's event
    always_comb begin
        enc_valid = 1'b0;
        enc_idx   = '0;
        enc_clr   = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                enc_valid  = 1'b1;
                enc_idx    = 3'(i);
                enc_clr    = '0;
                enc_clr[i] = 1'b1;
            end
        end
    end

`ifdef KEY_PORT_RELEASE_EVT_EN
    assign ev_dir = |(deb & enc_clr);
`else
    assign ev_dir = 1'b1;
`endif

    assign ev = {ev_dir, 4'b0000, enc_idx};

    // CTRL decode and FIFO handshake
    assign ctrl_wr  = we && (addr == A_CTRL);
    assign pop_req  = ctrl_wr & din[0];
    assign ovf_clr  = ctrl_wr & din[1];
    assign flush    = ctrl_wr & din[2];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop_req & ~empty & ~flush;
    assign push_req = enc_valid & ~flush;
    assign do_push  = push_req & (~full | do_pop);
    assign drop     = push_req & full & ~do_pop;

    // Pending mask: drained one per cycle, refilled by debounced edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~enc_clr) | set_mask;
        end
    end

    // FIFO storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= ev;
        end
    end

    // FIFO pointers, count, sticky overflow, interrupt enable and pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ie       <= 1'b0;
            key_int  <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (do_push) wptr <= wptr + AW'(1);
                if (do_pop)  rptr <= rptr + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (ctrl_wr) begin
                ie <= din[7];
            end
            key_int <= do_push & ie;
        end
    end

    // Register read mux
    always_comb begin
        rd_data = 8'h00;
        if (addr == A_DATA) begin
            rd_data = empty ? 8'h00 : mem[rptr];
        end else if (addr == A_STATUS) begin
            rd_data = {5'(count), overflow, full, empty};
        end else if (addr == A_CTRL) begin
            rd_data = {ie, 7'b0000000};
        end else if (addr == A_KEYS) begin
            rd_data = 8'(deb);
        end
    end

    // Read data is registered every cycle, one cycle behind addr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else begin
            dout <= rd_data;
        end
    end

endmodule
